// File: rtl/mmc_sort_pkg.sv
// mmc_sort_pkg: shared constants, binary32 container type and the
// float-to-unsigned sort key used by the MMC capacitor voltage sorter.
package mmc_sort_pkg;

  localparam int N_SM = 12;  // submodules per arm
  localparam int FP_W = 32;  // IEEE-754 binary32
  localparam int N_W  = 3;   // width of insertion count n

  typedef logic [FP_W-1:0] fp_t;

  // Key of +0.0; every value with the sign bit set maps strictly below it.
  localparam fp_t KEY_POS_ZERO = 32'h8000_0000;

  // Map a binary32 bit pattern onto an unsigned key whose integer order
  // matches float order (-0 sorts below +0, NaNs by bit pattern).
  function automatic fp_t fp_key(input fp_t x);
    fp_t k;
    if (x[FP_W-1]) begin
      k = ~x;
    end else begin
      k = x ^ KEY_POS_ZERO;
    end
    return k;
  endfunction

endpackage

// File: rtl/fp_key_cmp.sv
// fp_key_cmp: decides whether operand a precedes operand b in the
// insertion order. Charging prefers the lower voltage, discharging the
// higher one; equal keys fall back to the submodule index (A_LOWER set
// when a's index is below b's).
module fp_key_cmp
  import mmc_sort_pkg::*;
#(
  parameter bit A_LOWER = 1'b1
) (
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  input  logic            dis_i,
  output logic            precedes_o
);

  fp_t  ka_s;
  fp_t  kb_s;
  logic strict_s;

  // Key both operands, strict compare in the arm direction, then tie-break.
  always_comb begin
    ka_s = fp_key(a_i);
    kb_s = fp_key(b_i);
    if (dis_i) begin
      strict_s = (ka_s > kb_s);
    end else begin
      strict_s = (ka_s < kb_s);
    end
    precedes_o = strict_s | ((ka_s == kb_s) & A_LOWER);
  end

endmodule

// File: rtl/mmc_cap_voltage_sorter.sv
// mmc_cap_voltage_sorter: capacitor-voltage balancing sorter for one MMC
// arm. Stage 1 registers V1..V12, the current direction and n; stage 2
// registers M, where M[k] is set when fewer than n submodules precede k.
// Optional build macro MMC_SORT_VALID_EN adds in_valid/out_valid; stages
// then load only on valid data and M holds otherwise.
module mmc_cap_voltage_sorter
  import mmc_sort_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
`ifdef MMC_SORT_VALID_EN
  input  logic            in_valid,
  output logic            out_valid,
`endif
  input  logic [FP_W-1:0] V1,
  input  logic [FP_W-1:0] V2,
  input  logic [FP_W-1:0] V3,
  input  logic [FP_W-1:0] V4,
  input  logic [FP_W-1:0] V5,
  input  logic [FP_W-1:0] V6,
  input  logic [FP_W-1:0] V7,
  input  logic [FP_W-1:0] V8,
  input  logic [FP_W-1:0] V9,
  input  logic [FP_W-1:0] V10,
  input  logic [FP_W-1:0] V11,
  input  logic [FP_W-1:0] V12,
  input  logic [FP_W-1:0] I,
  input  logic [N_W-1:0]  n,
  output logic [N_SM:1]   M
);

  fp_t                        v_s [N_SM];
  fp_t                        v_q [N_SM];
  logic                       dis_s;
  logic                       dis_q;
  logic [N_W-1:0]             n_q;
  logic [N_SM-1:0][N_SM-1:0]  prec_s;   // prec_s[j][k]: j precedes k
  logic [3:0]                 rank_s [N_SM];
  logic [N_SM-1:0]            m_d;
  logic [N_SM-1:0]            m_q;
  logic                       load1_s;
  logic                       load2_s;

  assign v_s[0]  = V1;
  assign v_s[1]  = V2;
  assign v_s[2]  = V3;
  assign v_s[3]  = V4;
  assign v_s[4]  = V5;
  assign v_s[5]  = V6;
  assign v_s[6]  = V7;
  assign v_s[7]  = V8;
  assign v_s[8]  = V9;
  assign v_s[9]  = V10;
  assign v_s[10] = V11;
  assign v_s[11] = V12;

  // A negative current (sign set, -0.0 included) keys below +0.0.
  assign dis_s = (fp_key(I) < KEY_POS_ZERO);

`ifdef MMC_SORT_VALID_EN
  logic vld1_q;
  logic vld2_q;

  assign load1_s   = in_valid;
  assign load2_s   = vld1_q;
  assign out_valid = vld2_q;

  // Valid flag travels alongside the data, two clocks deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
    end else begin
      vld1_q <= in_valid;
      vld2_q <= vld1_q;
    end
  end
`else
  assign load1_s = 1'b1;
  assign load2_s = 1'b1;
`endif

  // Stage 1: capture voltages, arm direction and insertion count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SM; k++) begin
        v_q[k] <= '0;
      end
      dis_q <= 1'b0;
      n_q   <= '0;
    end else if (load1_s) begin
      for (int k = 0; k < N_SM; k++) begin
        v_q[k] <= v_s[k];
      end
      dis_q <= dis_s;
      n_q   <= n;
    end
  end

  // One comparator per ordered pair; a submodule never precedes itself.
  for (genvar j = 0; j < N_SM; j++) begin : g_row
    for (genvar k = 0; k < N_SM; k++) begin : g_col
      if (j != k) begin : g_cmp
        fp_key_cmp #(
          .A_LOWER (j < k)
        ) u_cmp (
          .a_i        (v_q[j]),
          .b_i        (v_q[k]),
          .dis_i      (dis_q),
          .precedes_o (prec_s[j][k])
        );
      end else begin : g_self
        assign prec_s[j][k] = 1'b0;
      end
    end
  end

  // Rank of each submodule is the count of those preceding it; the n
  // best-ranked submodules are inserted.
  always_comb begin
    for (int k = 0; k < N_SM; k++) begin
      rank_s[k] = 4'd0;
      for (int j = 0; j < N_SM; j++) begin
        rank_s[k] = rank_s[k] + {3'd0, prec_s[j][k]};
      end
      m_d[k] = (rank_s[k] < {1'b0, n_q});
    end
  end

  // Stage 2: register the insertion mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0;
    end else if (load2_s) begin
      m_q <= m_d;
    end
  end

  assign M = m_q;

endmodule

// File: tb/tb_mmc_cap_voltage_sorter.sv
// tb_mmc_cap_voltage_sorter: table of directed vectors, a randomized
// stream checked against a selection-sort reference model, and hand
// sequences for latency and asynchronous reset.
module tb_mmc_cap_voltage_sorter;

  logic        clk;
  logic        rst;
  logic [31:0] vin [12];
  logic [31:0] iin;
  logic [2:0]  nin;
  logic [12:1] M;
`ifdef MMC_SORT_VALID_EN
  logic        in_valid;
  logic        out_valid;
  assign in_valid = 1'b1;
`endif

  // staged stimulus, copied to the DUT inputs by drive()
  logic [31:0] sv [12];
  logic [31:0] si;
  logic [2:0]  sn;

  int n_vec = 0;
  int n_bad = 0;
  logic [11:0] hist [$];

  typedef struct {
    int          vsel;  // 0: reference set, 1: all 5.0, 2: -0/+0 then 5.0
    logic [31:0] i;
    logic [2:0]  n;
    logic [11:0] m;
  } vec_t;
  vec_t tbl [10];

  mmc_cap_voltage_sorter dut (
    .clk (clk),
    .rst (rst),
`ifdef MMC_SORT_VALID_EN
    .in_valid  (in_valid),
    .out_valid (out_valid),
`endif
    .V1 (vin[0]),  .V2 (vin[1]),  .V3 (vin[2]),   .V4 (vin[3]),
    .V5 (vin[4]),  .V6 (vin[5]),  .V7 (vin[6]),   .V8 (vin[7]),
    .V9 (vin[8]),  .V10(vin[9]),  .V11(vin[10]),  .V12(vin[11]),
    .I  (iin),
    .n  (nin),
    .M  (M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: M=%03h expected %03h at %0t", name, act, exp, $time);
    end
  endtask

  // float total order as an unsigned number
  function automatic logic [31:0] ref_key(input logic [31:0] x);
    if (x[31]) return ~x;
    return x | 32'h8000_0000;
  endfunction

  // Pick the best remaining submodule n times; scanning upward and
  // replacing only on a strictly better key keeps ties on the lower index.
  function automatic logic [11:0] model();
    logic [11:0] chosen;
    int best;
    chosen = 12'h000;
    for (int t = 0; t < int'(sn); t++) begin
      best = -1;
      for (int k = 0; k < 12; k++) begin
        if (!chosen[k]) begin
          if (best < 0) best = k;
          else if (si[31] && ref_key(sv[k]) > ref_key(sv[best])) best = k;
          else if (!si[31] && ref_key(sv[k]) < ref_key(sv[best])) best = k;
        end
      end
      chosen[best] = 1'b1;
    end
    return chosen;
  endfunction

  task automatic load_vset(input int sel);
    logic [31:0] base [12];
    base = '{32'h4140_0000, 32'h0000_0000, 32'h4150_0000, 32'h4120_0000,
             32'h40E0_0000, 32'h4110_0000, 32'h4198_0000, 32'h4188_0000,
             32'h42F0_0000, 32'h4214_0000, 32'h41C8_0000, 32'h41B8_0000};
    for (int k = 0; k < 12; k++) begin
      if (sel == 0) sv[k] = base[k];
      else sv[k] = 32'h40A0_0000;
    end
    if (sel == 2) begin
      sv[0] = 32'h8000_0000;
      sv[1] = 32'h0000_0000;
    end
  endtask

  // At each falling edge: check the result of the vector applied two
  // cycles ago, then present the staged vector.
  task automatic drive(input string name, input logic [11:0] exp);
    @(negedge clk);
    if (hist.size() >= 2) chk(name, M, hist[hist.size()-2]);
    for (int k = 0; k < 12; k++) vin[k] = sv[k];
    iin = si;
    nin = sn;
    hist.push_back(exp);
  endtask

  initial begin
    tbl[0] = '{0, 32'h41B8_0000, 3'd1, 12'h002};
    tbl[1] = '{0, 32'hC1B8_0000, 3'd3, 12'h700};
    tbl[2] = '{0, 32'h41B8_0000, 3'd7, 12'h0BF};
    tbl[3] = '{1, 32'h0000_0000, 3'd4, 12'h00F};
    tbl[4] = '{0, 32'h41B8_0000, 3'd0, 12'h000};
    tbl[5] = '{0, 32'hC1B8_0000, 3'd0, 12'h000};
    tbl[6] = '{1, 32'h8000_0000, 3'd4, 12'h00F};
    tbl[7] = '{0, 32'hC1B8_0000, 3'd7, 12'hFC4};
    tbl[8] = '{2, 32'h41B8_0000, 3'd1, 12'h001};
    tbl[9] = '{2, 32'hC1B8_0000, 3'd1, 12'h004};

    for (int k = 0; k < 12; k++) vin[k] = 32'h0;
    iin = 32'h0;
    nin = 3'd0;
    rst = 1'b1;
    #2;
    chk("reset", M, 12'h000);
    @(negedge clk);
    rst = 1'b0;

    // directed table
    for (int t = 0; t < 10; t++) begin
      load_vset(tbl[t].vsel);
      si = tbl[t].i;
      sn = tbl[t].n;
      drive($sformatf("table%0d", t - 2), tbl[t].m);
    end

    // randomized stream against the reference model
    for (int t = 0; t < 300; t++) begin
      for (int k = 0; k < 12; k++) begin
        case ($urandom_range(0, 2))
          0: sv[k] = $urandom;
          1: case ($urandom_range(0, 5))
               0: sv[k] = 32'h0000_0000;
               1: sv[k] = 32'h8000_0000;
               2: sv[k] = 32'h40A0_0000;
               3: sv[k] = 32'hC0A0_0000;
               4: sv[k] = 32'h4120_0000;
               default: sv[k] = 32'h7FC0_0000;
             endcase
          default: sv[k] = 32'h4100_0000 + (32'($urandom_range(0, 3)) << 20);
        endcase
      end
      case ($urandom_range(0, 5))
        0: si = 32'h0000_0000;
        1: si = 32'h8000_0000;
        default: si = $urandom;
      endcase
      sn = 3'($urandom_range(0, 7));
      drive("random", model());
    end
    drive("flush", model());
    drive("flush", model());

    // asynchronous reset mid-stream, then restart latency
    load_vset(0);
    si = 32'hC1B8_0000;
    sn = 3'd3;
    drive("hold", 12'h700);
    repeat (2) @(negedge clk);
    chk("pre_rst", M, 12'h700);
    #2 rst = 1'b1;
    #1 chk("async_rst", M, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_edge1", M, 12'h000);
    @(posedge clk);
    #1 chk("post_rst_edge2", M, 12'h700);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
